decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered, handshaked RISC-V RV32I decode stage for the simple CPU. It sits between fetch and execute. It classifies the opcode into one-hot control flags, extracts register indices, builds the sign-extended immediate and flags illegal encodings. It contains a one-deep skid buffer so that `in_ready` never combinationally depends on `out_ready`.

Parameters:
- XLEN, 32: datapath width of `out_imm` (legal values 32 and 64); immediates sign-extend to XLEN.
- PC_W, 32: width of the program counter carried alongside the instruction.
- EN_SYSTEM, 1: 1 decodes opcode 1110011 as `is_system`; 0 treats it as illegal.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- flush, input, 1: discard all held instructions (branch redirect).
- in_valid, input, 1: fetch presents an instruction.
- in_ready, output, 1: stage can accept; registered.
- in_instr, input, 32: raw instruction word.
- in_pc, input, PC_W: PC of `in_instr`.
- out_valid, output, 1: decoded bundle valid.
- out_ready, input, 1: execute accepts the bundle.
- out_pc, output, PC_W: PC of the decoded instruction.
- out_rd / out_rs1 / out_rs2, output, 5 each: `instr[11:7]`, `[19:15]`, `[24:20]`.
- out_funct3, output, 3: `instr[14:12]`.
- out_funct7b5, output, 1: `instr[30]`.
- out_imm, output, XLEN: sign-extended immediate.
- out_ctrl, output, 11, one-hot class flags plus write enable:
  - [0] alu_reg, [1] alu_imm, [2] branch, [3] jal, [4] jalr, [5] lui
  - [6] auipc, [7] load, [8] store, [9] system, [10] reg_write
- out_illegal, output, 1: unrecognised or illegal encoding.

Behaviour:
- Opcode map (`instr[6:0]`):
  - 0110011 alu_reg; 0010011 alu_imm; 1100011 branch; 1101111 jal; 1100111 jalr
  - 0110111 lui; 0010111 auipc; 0000011 load; 0100011 store; 1110011 system (if EN_SYSTEM)
- reg_write = alu_reg|alu_imm|jal|jalr|lui|auipc|load, forced 0 when rd==0. Branch, store and system give reg_write=0.
- Illegal when any of these holds:
  - `instr[1:0]` != 11;
  - opcode is not in the map;
  - jalr with funct3 != 000.
- On illegal: `out_ctrl` = 0 and `out_illegal` = 1. The bundle still flows through the pipeline.
- Immediate per format, sign bit `instr[31]` replicated to XLEN:
  - I for alu_imm/load/jalr/system;
  - S for store;
  - B for branch (bit0 = 0);
  - U for lui/auipc (low 12 bits = 0);
  - J for jal (bit0 = 0);
  - 0 for alu_reg and illegal.
- Storage: main register M plus skid register S. States EMPTY, ONE (M valid) and FULL (M and S valid). All transitions happen on the clk edge.
- Transfer rules: input transfers when `in_valid && in_ready`; output transfers when `out_valid && out_ready`. Decode is combinational from the instruction and is captured into M or S.
- EMPTY:
  - input transfer → ONE.
- ONE:
  - input only → FULL (new bundle in S);
  - output only → EMPTY;
  - both → ONE (M replaced by the new bundle).
- FULL (`in_ready` = 0):
  - output transfer → ONE (S moves to M);
  - otherwise hold.
- `in_ready` is a register equal to (next state != FULL). `out_valid` = (state != EMPTY). Outputs are always driven from M.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N; throughput is 1 per cycle with `out_ready` held high.
- Outputs must hold stable while `out_valid && !out_ready`.
- flush has priority over everything:
  - next state is EMPTY;
  - any same-cycle input is dropped;
  - `in_ready` = 1 next cycle.
- Reset values:
  - state EMPTY, `out_valid` 0, `in_ready` 1;
  - `out_ctrl`, `out_imm`, `out_pc`, reg fields, `out_funct3`, `out_funct7b5` and `out_illegal` all 0.
- rst mid-operation discards M and S exactly like flush and zeroes all outputs.

Test Plan:
1. Streaming, `out_ready` = 1, nine instructions pushed back to back:
   - add x3,x1,x2 (0x002081B3) → ctrl 0x401;
   - addi x3,x1,5 (0x00508193) → ctrl 0x402, imm 5;
   - lw x3,4(x1) (0x0040A183) → ctrl 0x480, imm 4;
   - sw x3,4(x1) (0x0030A223) → ctrl 0x100, imm 4;
   - beq x1,x3,+4 (0x00308263) → ctrl 0x004, imm 4;
   - jalr x3,4(x1) (0x004081E7) → ctrl 0x410, imm 4;
   - jal x3,0 (0x000001EF) → ctrl 0x408, imm 0;
   - lui x3,1 (0x000011B7) → ctrl 0x420, imm 0x1000;
   - auipc x3,1 (0x00001197) → ctrl 0x440, imm 0x1000.
   - Also required: each bundle is valid one cycle after acceptance and no bubbles appear.
2. Sign extension:
   - addi x1,x0,-1 (0xFFF00093) → imm 0xFFFFFFFF (XLEN=64: 0xFFFFFFFFFFFFFFFF);
   - beq with offset -2 (0xFE000FE3) → imm 0xFFFFFFFE.
3. Backpressure:
   - push A, B, C with `out_ready` = 0 → A and B held;
   - `in_ready` falls after B is accepted; C is not accepted;
   - outputs stay at A unchanged;
   - raise `out_ready` → A, B, C emerge in order with no loss or duplication.
4. Illegal encodings and rd==0:
   - 0x00000000 → illegal=1, ctrl=0;
   - opcode 1111111 → illegal;
   - ecall (0x00000073) with EN_SYSTEM=0 → illegal;
   - add x0,x1,x2 (0x00208033) → ctrl 0x001 (reg_write 0).
5. Flush in the FULL state with `in_valid` high → next cycle `out_valid` = 0 and `in_ready` = 1; the dropped instruction never appears at the output.
6. rst asserted for one cycle while in ONE → all outputs 0 and `in_ready` = 1 after the edge; normal streaming resumes on the next cycle.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the incoming word captured into a
// main/skid register pair so that in_ready is a pure register output.
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter bit EN_SYSTEM = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic [XLEN-1:0] out_imm,
    output logic [10:0]     out_ctrl,
    output logic            out_illegal
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [XLEN-1:0] imm;
        logic [10:0]     ctrl;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t  state, state_nx;
    bundle_t dec, m_q, s_q, m_nx;
    logic    load_m, load_s;
    logic    in_xfer, out_xfer;

    logic [6:0]  opcode;
    logic [9:0]  cls;
    logic [31:0] imm32;
    logic        bad, reg_write;

    // Handshake: a beat moves on a rising edge only when valid and ready are both
    // high; valid never waits on ready, and a held beat keeps its payload stable.
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        opcode = in_instr[6:0];
        cls    = '0;
        imm32  = '0;
        bad    = 1'b0;
        unique case (opcode)
            7'b0110011: cls[0] = 1'b1;
            7'b0010011: begin cls[1] = 1'b1; imm32 = {{20{in_instr[31]}}, in_instr[31:20]}; end
            7'b1100011: begin
                cls[2] = 1'b1;
                imm32  = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b1101111: begin
                cls[3] = 1'b1;
                imm32  = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b1100111: begin
                cls[4] = 1'b1;
                imm32  = {{20{in_instr[31]}}, in_instr[31:20]};
                bad    = (in_instr[14:12] != 3'b000);
            end
            7'b0110111: begin cls[5] = 1'b1; imm32 = {in_instr[31:12], 12'b0}; end
            7'b0010111: begin cls[6] = 1'b1; imm32 = {in_instr[31:12], 12'b0}; end
            7'b0000011: begin cls[7] = 1'b1; imm32 = {{20{in_instr[31]}}, in_instr[31:20]}; end
            7'b0100011: begin
                cls[8] = 1'b1;
                imm32  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1110011: begin
                if (EN_SYSTEM) begin
                    cls[9] = 1'b1;
                    imm32  = {{20{in_instr[31]}}, in_instr[31:20]};
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11) bad = 1'b1;

        reg_write = (|(cls & 10'b00_1111_1011)) && (in_instr[11:7] != 5'd0);

        dec          = '0;
        dec.pc       = in_pc;
        dec.rd       = in_instr[11:7];
        dec.rs1      = in_instr[19:15];
        dec.rs2      = in_instr[24:20];
        dec.funct3   = in_instr[14:12];
        dec.funct7b5 = in_instr[30];
        dec.illegal  = bad;
        dec.ctrl     = bad ? 11'd0 : {reg_write, cls};
        dec.imm      = bad ? '0 : XLEN'($signed(imm32));
    end

    always_comb begin
        state_nx = state;
        load_m   = 1'b0;
        load_s   = 1'b0;
        m_nx     = dec;
        unique case (state)
            EMPTY: if (in_xfer) begin
                state_nx = ONE;
                load_m   = 1'b1;
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_m = 1'b1;
                end else if (in_xfer) begin
                    state_nx = FULL;
                    load_s   = 1'b1;
                end else if (out_xfer) begin
                    state_nx = EMPTY;
                end
            end
            FULL: if (out_xfer) begin
                state_nx = ONE;
                load_m   = 1'b1;
                m_nx     = s_q;
            end
            default: state_nx = EMPTY;
        endcase
        // A redirect wins over any same-cycle movement, including a new input.
        if (flush) begin
            state_nx = EMPTY;
            load_m   = 1'b0;
            load_s   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            m_q      <= '0;
            s_q      <= '0;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx != FULL);
            if (load_m) m_q <= m_nx;
            if (load_s) s_q <= dec;
        end
    end

    assign out_valid    = (state != EMPTY);
    assign out_pc       = m_q.pc;
    assign out_rd       = m_q.rd;
    assign out_rs1      = m_q.rs1;
    assign out_rs2      = m_q.rs2;
    assign out_funct3   = m_q.funct3;
    assign out_funct7b5 = m_q.funct7b5;
    assign out_imm      = m_q.imm;
    assign out_ctrl     = m_q.ctrl;
    assign out_illegal  = m_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed test-plan sequences plus random traffic, checked
// against an ISA-level decode model and a FIFO model of the two-entry buffer.
module tb_decode_stage;
    localparam int XLEN = 32;
    localparam int PC_W = 32;
    localparam int W    = PC_W + 32;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, out_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            in_ready, out_valid, out_funct7b5, out_illegal;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      out_rd, out_rs1, out_rs2;
    logic [2:0]      out_funct3;
    logic [XLEN-1:0] out_imm;
    logic [10:0]     out_ctrl;

    logic            sys_in_ready, sys_out_valid, sys_funct7b5, sys_illegal;
    logic [PC_W-1:0] sys_pc;
    logic [4:0]      sys_rd, sys_rs1, sys_rs2;
    logic [2:0]      sys_funct3;
    logic [XLEN-1:0] sys_imm;
    logic [10:0]     sys_ctrl;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .EN_SYSTEM(1'b0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_imm(out_imm),
        .out_ctrl(out_ctrl), .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .EN_SYSTEM(1'b1)) dut_sys (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(sys_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(sys_out_valid), .out_ready(out_ready),
        .out_pc(sys_pc), .out_rd(sys_rd), .out_rs1(sys_rs1), .out_rs2(sys_rs2),
        .out_funct3(sys_funct3), .out_funct7b5(sys_funct7b5), .out_imm(sys_imm),
        .out_ctrl(sys_ctrl), .out_illegal(sys_illegal)
    );

    typedef struct {
        logic [10:0]     ctrl;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } ref_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        else n_pass++;
    endtask

    // Signed value of an unsigned field of the given width.
    function automatic longint sext(input longint v, input int width);
        return (v >= (longint'(1) << (width - 1))) ? v - (longint'(1) << width) : v;
    endfunction

    function automatic ref_t ref_decode(input logic [31:0] ins, input bit en_sys);
        ref_t   r;
        int     cls = -1;
        longint v   = 0;
        bit     ill = 0;
        case (ins[6:0])
            7'h33: cls = 0;
            7'h13: begin cls = 1; v = sext(ins[31:20], 12); end
            7'h63: begin
                cls = 2;
                v = sext(ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2, 13);
            end
            7'h6f: begin
                cls = 3;
                v = sext(ins[31] * (1 << 20) + ins[19:12] * (1 << 12) + ins[20] * 2048
                         + ins[30:21] * 2, 21);
            end
            7'h67: begin cls = 4; v = sext(ins[31:20], 12); ill = (ins[14:12] != 0); end
            7'h37: begin cls = 5; v = sext(longint'(ins[31:12]) * 4096, 32); end
            7'h17: begin cls = 6; v = sext(longint'(ins[31:12]) * 4096, 32); end
            7'h03: begin cls = 7; v = sext(ins[31:20], 12); end
            7'h23: begin cls = 8; v = sext(ins[31:25] * 32 + ins[11:7], 12); end
            7'h73: if (en_sys) begin cls = 9; v = sext(ins[31:20], 12); end else ill = 1;
            default: ill = 1;
        endcase
        r.illegal = ill;
        if (ill) begin
            r.ctrl = 0;
            r.imm  = 0;
        end else begin
            r.ctrl = 11'(1 << cls);
            if (cls inside {0, 1, 3, 4, 5, 6, 7} && ins[11:7] != 0) r.ctrl[10] = 1'b1;
            r.imm = XLEN'(v);
        end
        return r;
    endfunction

    // One clock: drive, check held bundle against the queue front, then advance the model.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        logic [W-1:0] f;
        ref_t         r, rs;
        bit           acc, pop;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = PC_W'($urandom) & ~PC_W'(3);
        out_ready = ordy;
        flush     = fl;
        #1;
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
        if (exp_q.size() != 0 && out_valid) begin
            f  = exp_q[0];
            r  = ref_decode(f[31:0], 1'b0);
            rs = ref_decode(f[31:0], 1'b1);
            check("pc", 64'(out_pc), 64'(f[W-1:32]));
            check("rd", 64'(out_rd), 64'(f[11:7]));
            check("rs1", 64'(out_rs1), 64'(f[19:15]));
            check("rs2", 64'(out_rs2), 64'(f[24:20]));
            check("funct3", 64'(out_funct3), 64'(f[14:12]));
            check("funct7b5", 64'(out_funct7b5), 64'(f[30]));
            check("imm", 64'(out_imm), 64'(r.imm));
            check("ctrl", 64'(out_ctrl), 64'(r.ctrl));
            check("illegal", 64'(out_illegal), 64'(r.illegal));
            check("sys_ctrl", 64'(sys_ctrl), 64'(rs.ctrl));
            check("sys_imm", 64'(sys_imm), 64'(rs.imm));
            check("sys_illegal", 64'(sys_illegal), 64'(rs.illegal));
        end
        acc = v && (exp_q.size() < 2);
        pop = ordy && (exp_q.size() != 0);
        @(posedge clk);
        if (fl || rst) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({in_pc, ins});
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[10] = '{7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h03, 7'h23, 7'h73};
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 99) < 85) w[6:0] = ops[$urandom_range(0, 9)];
        if (w[6:0] == 7'h67 && $urandom_range(0, 1) == 1) w[14:12] = 3'b000;
        return w;
    endfunction

    logic [31:0] st_ins[9]  = '{32'h002081B3, 32'h00508193, 32'h0040A183, 32'h0030A223,
                                32'h00308263, 32'h004081E7, 32'h000001EF, 32'h000011B7, 32'h00001197};
    logic [10:0] st_ctrl[9] = '{11'h401, 11'h402, 11'h480, 11'h100, 11'h004, 11'h410, 11'h408,
                                11'h420, 11'h440};
    logic [31:0] st_imm[9]  = '{0, 5, 4, 4, 4, 4, 0, 32'h1000, 32'h1000};
    logic [31:0] ab_ins[4]  = '{32'hFFF00093, 32'hFE000FE3, 32'h00000000, 32'h0000007F};
    logic [10:0] ab_ctrl[4] = '{11'h402, 11'h004, 11'h000, 11'h000};
    logic [31:0] ab_imm[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0};

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_in_ready", 64'(in_ready), 1);
        check("rst_ctrl", 64'(out_ctrl), 0);
        check("rst_imm", 64'(out_imm), 0);
        check("rst_fields", 64'({out_pc, out_rd, out_rs1, out_rs2, out_funct3, out_funct7b5,
                                 out_illegal}), 0);

        // Back-to-back streaming against literal expectations.
        for (int k = 0; k < 9; k++) begin
            cycle(1'b1, st_ins[k], 1'b1, 1'b0);
            check("stream_valid", 64'(out_valid), 1);
            check("stream_ctrl", 64'(out_ctrl), 64'(st_ctrl[k]));
            check("stream_imm", 64'(out_imm), 64'(st_imm[k]));
        end
        // Sign extension and illegal words.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, ab_ins[k], 1'b1, 1'b0);
            check("edge_ctrl", 64'(out_ctrl), 64'(ab_ctrl[k]));
            check("edge_imm", 64'(out_imm), 64'(ab_imm[k]));
            check("edge_illegal", 64'(out_illegal), 64'(k >= 2));
        end
        cycle(1'b1, 32'h00000073, 1'b1, 1'b0);
        check("ecall_illegal", 64'(out_illegal), 1);
        check("ecall_sys_ctrl", 64'(sys_ctrl), 64'h200);
        cycle(1'b1, 32'h00208033, 1'b1, 1'b0);
        check("add_x0_ctrl", 64'(out_ctrl), 64'h001);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: A, B held; C refused until the consumer drains.
        cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200113, 1'b0, 1'b0);
        check("bp_in_ready_low", 64'(in_ready), 0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'h00300193, 1'b0, 1'b0);
            check("bp_hold_a", 64'(out_rd), 1);
        end
        cycle(1'b1, 32'h00300193, 1'b1, 1'b0);
        cycle(1'b1, 32'h00300193, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("bp_drained", 64'(exp_q.size()), 0);

        // Flush while full with a new word on the input.
        cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200113, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300193, 1'b0, 1'b1);
        check("flush_out_valid", 64'(out_valid), 0);
        check("flush_in_ready", 64'(in_ready), 1);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Reset while one bundle is held.
        cycle(1'b1, 32'h00508193, 1'b0, 1'b0);
        rst = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        check("rrst_out_valid", 64'(out_valid), 0);
        check("rrst_in_ready", 64'(in_ready), 1);
        check("rrst_outputs", 64'({out_pc, out_rd, out_rs1, out_rs2, out_funct3, out_funct7b5,
                                   out_illegal}) | 64'(out_imm) | 64'(out_ctrl), 0);
        for (int k = 0; k < 3; k++) cycle(1'b1, st_ins[k], 1'b1, 1'b0);

        // Random traffic.
        for (int k = 0; k < 600; k++)
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 99) < 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
